dg0045_ram_arbiter: RTL and testbench



---
 rtl/dg0045_pkg.sv | 23 ++
 rtl/dg0045_ram_arbiter_resp.sv | 48 ++++
 rtl/dg0045_ram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dg0045_ram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dg0045_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dg0045_pkg                                             |
// | Description : Shared constants and arbiter state encoding for the    |
// |               DG0045 data RAM and its access arbiter.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dg0045_pkg;

  // Data RAM geometry, reused by the CPU core and the RAM wrapper.
  localparam int RAM_ADDR_W = 6;
  localparam int NIBBLE_W   = 4;

  // Arbiter state: which requester touched the RAM last, or AUX burst ownership.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_AUX  = 2'd2,
    ARB_LOCK = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dg0045_ram_arbiter_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dg0045_arb_resp                                        |
// | Description : Per-port read response register. Captures RAM read    |
// |               data one cycle after an accepted read and pulses       |
// |               rvalid; rdata holds until the next response.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dg0045_arb_resp
  import dg0045_pkg::*;
#(
  parameter int DATA_W = NIBBLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_accept,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  logic              rvalid_q;
  logic              rvalid_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Next response: pulse on every accepted read, otherwise keep the old data.
  always_comb begin
    rvalid_d = rd_accept;
    rdata_d  = rd_accept ? ram_dout : rdata_q;
  end

  // Response registers; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dg0045_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dg0045_ram_arbiter                                     |
// | Description : Single-port arbiter for the 64x4 DG0045 data RAM.      |
// |               CPU has priority; a streak counter bounds AUX wait     |
// |               and a bounded lock mode gives AUX burst ownership.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dg0045_ram_arbiter
  import dg0045_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = NIBBLE_W,
  parameter int MAX_WAIT = 7,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // AUX port
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic              aux_lock,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  // RAM macro
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  // Debug
  output logic [1:0]        arb_state
);

  localparam int                   c_LOCK_CW   = $clog2(LOCK_MAX);
  localparam logic [3:0]           c_MAX_WAIT  = 4'(MAX_WAIT);
  localparam logic [c_LOCK_CW-1:0] c_LOCK_LAST = c_LOCK_CW'(LOCK_MAX - 1);
  localparam logic [c_LOCK_CW-1:0] c_LOCK_ONE  = c_LOCK_CW'(1);

  arb_state_e           state_q;
  arb_state_e           state_d;
  logic [3:0]           streak_q;
  logic [3:0]           streak_d;
  logic [c_LOCK_CW-1:0] lock_cnt_q;
  logic [c_LOCK_CW-1:0] lock_cnt_d;
  logic                 lock_block_q;
  logic                 lock_block_d;

  logic w_in_lock;
  logic w_cpu_gnt;
  logic w_aux_gnt;
  logic w_lock_limit;
  logic w_lock_exit;
  logic w_lock_entry;

  assign w_in_lock    = (state_q == ARB_LOCK);
  // Limit reached at this edge: AUX has now owned the RAM for LOCK_MAX cycles.
  assign w_lock_limit = w_in_lock && (lock_cnt_q == c_LOCK_LAST);
  assign w_lock_exit  = w_in_lock && (!aux_lock || w_lock_limit);
  assign w_lock_entry = !w_in_lock && w_aux_gnt && aux_lock && !lock_block_q;

  // Grant decision: LOCK hands the RAM to AUX, otherwise CPU wins unless AUX has starved.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_aux_gnt = 1'b0;
    if (!rst) begin
      if (w_in_lock) begin
        w_aux_gnt = aux_req;
      end else if (cpu_req && aux_req) begin
        if (streak_q == c_MAX_WAIT) begin
          w_aux_gnt = 1'b1;
        end else begin
          w_cpu_gnt = 1'b1;
        end
      end else begin
        w_cpu_gnt = cpu_req;
        w_aux_gnt = aux_req;
      end
    end
  end

  // Next FSM state, streak, lock length and re-lock block.
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    lock_cnt_d   = lock_cnt_q;
    lock_block_d = lock_block_q;

    if (w_in_lock) begin
      if (w_lock_exit) begin
        state_d    = cpu_req ? ARB_CPU : ARB_IDLE;
        lock_cnt_d = '0;
      end else begin
        state_d    = ARB_LOCK;
        lock_cnt_d = lock_cnt_q + c_LOCK_ONE;
      end
    end else if (w_lock_entry) begin
      state_d    = ARB_LOCK;
      lock_cnt_d = c_LOCK_ONE;
    end else if (w_cpu_gnt) begin
      state_d = ARB_CPU;
    end else if (w_aux_gnt) begin
      state_d = ARB_AUX;
    end else begin
      state_d = ARB_IDLE;
    end

    // Streak counts CPU wins over a waiting AUX and saturates at the forcing point.
    if (w_aux_gnt || !aux_req || w_lock_exit) begin
      streak_d = '0;
    end else if (w_cpu_gnt && (streak_q < c_MAX_WAIT)) begin
      streak_d = streak_q + 4'd1;
    end

    // A limit-forced exit blocks re-lock until AUX lets go of aux_lock once.
    if (!aux_lock) begin
      lock_block_d = 1'b0;
    end else if (w_lock_limit) begin
      lock_block_d = 1'b1;
    end
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      streak_q     <= '0;
      lock_cnt_q   <= '0;
      lock_block_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_block_q <= lock_block_d;
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign aux_gnt   = w_aux_gnt;
  assign arb_state = state_q;

  // RAM datapath follows the granted port; CPU address is the idle default.
  assign ram_addr = w_aux_gnt ? aux_addr  : cpu_addr;
  assign ram_din  = w_aux_gnt ? aux_wdata : cpu_wdata;
  assign ram_we   = (w_cpu_gnt & cpu_we) | (w_aux_gnt & aux_we);

  dg0045_arb_resp #(
    .DATA_W (DATA_W)
  ) u_cpu_resp (
    .clk       (clk),
    .rst       (rst),
    .rd_accept (w_cpu_gnt & ~cpu_we),
    .ram_dout  (ram_dout),
    .rvalid    (cpu_rvalid),
    .rdata     (cpu_rdata)
  );

  dg0045_arb_resp #(
    .DATA_W (DATA_W)
  ) u_aux_resp (
    .clk       (clk),
    .rst       (rst),
    .rd_accept (w_aux_gnt & ~aux_we),
    .ram_dout  (ram_dout),
    .rvalid    (aux_rvalid),
    .rdata     (aux_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_dg0045_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dg0045_ram_arbiter                                  |
// | Description : Self-checking bench for dg0045_ram_arbiter with a      |
// |               behavioural RAM and an ownership-level reference model.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_dg0045_ram_arbiter;

  localparam int MAX_WAIT = 7;
  localparam int LOCK_MAX = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [5:0] cpu_addr;
  logic [3:0] cpu_wdata, cpu_rdata;
  logic       aux_req, aux_we, aux_lock, aux_gnt, aux_rvalid;
  logic [5:0] aux_addr;
  logic [3:0] aux_wdata, aux_rdata;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_din, ram_dout;
  logic [1:0] arb_state;

  dg0045_ram_arbiter #(
    .ADDR_W   (6),
    .DATA_W   (4),
    .MAX_WAIT (MAX_WAIT),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .aux_req    (aux_req),
    .aux_we     (aux_we),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_lock   (aux_lock),
    .aux_gnt    (aux_gnt),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .arb_state  (arb_state)
  );

  // Behavioural RAM macro: asynchronous read, write on the clock edge.
  logic [3:0] tb_ram [64];
  logic       pre_we;
  logic [5:0] pre_addr;
  logic [3:0] pre_data;
  assign ram_dout = tb_ram[ram_addr];
  always @(posedge clk) begin
    if (pre_we) tb_ram[pre_addr] <= pre_data;
    else if (ram_we) tb_ram[ram_addr] <= ram_din;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] preload_val(input int i);
    if (i == 'h15) return 4'hA;
    return 4'(i * 5 + 1);
  endfunction

  // Reference model: who owns the RAM, how long AUX has been passed over,
  // and how many cycles the current AUX burst has lasted.
  logic [3:0] m_mem [64];
  int         m_wait;
  int         m_age;
  bit         m_locked;
  bit         m_blocked;
  logic [1:0] m_state;
  bit         m_cpu_rv, m_aux_rv;
  logic [3:0] m_cpu_rd, m_aux_rd;
  bit         m_gc, m_ga;

  // Observations of the last evaluated cycle, for directed checks.
  logic       o_cg, o_ag, o_crv, o_arv, o_we;
  logic [1:0] o_state;
  logic [3:0] o_crd, o_ard;

  task automatic model_reset();
    m_wait = 0; m_age = 0; m_locked = 0; m_blocked = 0; m_state = 2'd0;
    m_cpu_rv = 0; m_aux_rv = 0; m_cpu_rd = 4'h0; m_aux_rd = 4'h0;
  endtask

  task automatic model_step();
    bit eg_cpu, eg_aux;
    o_cg = cpu_gnt; o_ag = aux_gnt; o_crv = cpu_rvalid; o_arv = aux_rvalid;
    o_crd = cpu_rdata; o_ard = aux_rdata; o_state = arb_state; o_we = ram_we;

    check("arb_state", arb_state, m_state);
    check("cpu_rvalid", cpu_rvalid, m_cpu_rv);
    check("cpu_rdata", cpu_rdata, m_cpu_rd);
    check("aux_rvalid", aux_rvalid, m_aux_rv);
    check("aux_rdata", aux_rdata, m_aux_rd);

    eg_cpu = 0; eg_aux = 0;
    if (!rst) begin
      if (m_locked) eg_aux = aux_req;
      else if (cpu_req && aux_req) begin
        eg_aux = (m_wait >= MAX_WAIT);
        eg_cpu = !eg_aux;
      end else begin
        eg_cpu = cpu_req;
        eg_aux = aux_req;
      end
    end
    check("cpu_gnt", cpu_gnt, eg_cpu);
    check("aux_gnt", aux_gnt, eg_aux);
    check("ram_we", ram_we, (eg_cpu && cpu_we) || (eg_aux && aux_we));
    check("ram_addr", ram_addr, eg_aux ? aux_addr : cpu_addr);
    if (eg_cpu) check("ram_din_cpu", ram_din, cpu_wdata);
    if (eg_aux) check("ram_din_aux", ram_din, aux_wdata);
    m_gc = eg_cpu; m_ga = eg_aux;

    if (rst) begin
      model_reset();
    end else begin
      m_cpu_rv = eg_cpu && !cpu_we;
      m_aux_rv = eg_aux && !aux_we;
      if (m_cpu_rv) m_cpu_rd = m_mem[cpu_addr];
      if (m_aux_rv) m_aux_rd = m_mem[aux_addr];
      if (eg_cpu && cpu_we) m_mem[cpu_addr] = cpu_wdata;
      if (eg_aux && aux_we) m_mem[aux_addr] = aux_wdata;

      if (!aux_req || eg_aux) m_wait = 0;
      else if (eg_cpu && m_wait < MAX_WAIT) m_wait++;

      if (m_locked) begin
        m_age++;
        if (!aux_lock || m_age == LOCK_MAX) begin
          if (aux_lock) m_blocked = 1;
          m_locked = 0;
          m_wait   = 0;
          m_state  = cpu_req ? 2'd1 : 2'd0;
        end else begin
          m_state = 2'd3;
        end
      end else if (eg_aux && aux_lock && !m_blocked) begin
        m_locked = 1;
        m_age    = 1;
        m_state  = 2'd3;
      end else begin
        m_state = eg_cpu ? 2'd1 : (eg_aux ? 2'd2 : 2'd0);
      end
      if (!aux_lock) m_blocked = 0;
    end
  endtask

  // One clock cycle: evaluate at the falling edge, then move past the rising edge.
  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Random requesters that respect the hold-until-grant protocol.
  task automatic drive_random();
    if (!cpu_req || m_gc) begin
      cpu_req   = ($urandom_range(0, 99) < 60);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 6'($urandom_range(0, 15));
      cpu_wdata = 4'($urandom_range(0, 15));
    end
    if (!aux_req || m_ga) begin
      aux_req   = ($urandom_range(0, 99) < 50);
      aux_we    = 1'($urandom_range(0, 1));
      aux_addr  = 6'($urandom_range(0, 15));
      aux_wdata = 4'($urandom_range(0, 15));
    end
    if ($urandom_range(0, 9) == 0) aux_lock = !aux_lock;
    rst = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_a;
    rst = 1; pre_we = 0; pre_addr = '0; pre_data = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0; aux_lock = 0;
    m_gc = 0; m_ga = 0;
    for (int i = 0; i < 64; i++) begin
      pre_we = 1; pre_addr = 6'(i); pre_data = preload_val(i);
      m_mem[i] = preload_val(i);
      @(posedge clk); #1;
    end
    pre_we = 0;
    model_reset();
    cyc();
    rst = 0;
    cyc();
    check("rst_state", o_state, 2'd0);
    check("rst_cpu_rvalid", o_crv, 1'b0);
    check("rst_aux_rvalid", o_arv, 1'b0);
    check("rst_cpu_rdata", o_crd, 4'h0);
    check("rst_aux_rdata", o_ard, 4'h0);

    // CPU read of a preloaded nibble with AUX quiet.
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'h15;
    cyc();
    check("t1_cpu_gnt", o_cg, 1'b1);
    check("t1_aux_gnt", o_ag, 1'b0);
    cpu_req = 0;
    cyc();
    check("t1_rvalid", o_crv, 1'b1);
    check("t1_rdata", o_crd, 4'hA);
    check("t1_aux_gnt_next", o_ag, 1'b0);

    // Continuous contention: seven CPU slots then one forced AUX slot.
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'h01;
    aux_req = 1; aux_we = 0; aux_addr = 6'h02; aux_lock = 0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      check("t2_aux_gnt", o_ag, (i % 8) == 7);
      check("t2_cpu_gnt", o_cg, (i % 8) != 7);
    end
    cpu_req = 0; aux_req = 0;
    cyc();

    // AUX write followed immediately by a CPU read of the same address.
    aux_req = 1; aux_we = 1; aux_addr = 6'h2F; aux_wdata = 4'h3;
    cyc();
    check("t3_aux_gnt", o_ag, 1'b1);
    aux_req = 0; aux_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'h2F;
    cyc();
    check("t3_cpu_gnt", o_cg, 1'b1);
    cpu_req = 0;
    cyc();
    check("t3_rvalid", o_crv, 1'b1);
    check("t3_rdata", o_crd, 4'h3);

    // Lock against a busy CPU: forced-through entry, LOCK_MAX cycles, then blocked.
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'h05;
    aux_req = 1; aux_we = 0; aux_addr = 6'h06; aux_lock = 1;
    for (int i = 0; i <= 30; i++) begin
      cyc();
      exp_a = (i >= 7 && i <= 22) || (i == 30);
      check("t4_aux_gnt", o_ag, exp_a);
      check("t4_cpu_gnt", o_cg, !exp_a);
      if (i == 22) check("t4_state_lock", o_state, 2'd3);
      if (i == 23) check("t4_state_cpu", o_state, 2'd1);
    end
    aux_lock = 0;
    cyc();
    check("t4_no_relock", o_state, 2'd2);
    aux_lock = 1; cpu_req = 0;
    cyc();
    check("t4_relock_gnt", o_ag, 1'b1);
    cyc();
    check("t4_relock_state", o_state, 2'd3);
    aux_lock = 0; aux_req = 0;
    cyc();
    cyc();

    // Short lock released by AUX while the CPU waits.
    aux_req = 1; aux_we = 1; aux_addr = 6'h10; aux_wdata = 4'h7; aux_lock = 1;
    cyc();
    check("t5_entry_gnt", o_ag, 1'b1);
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'h11; cpu_wdata = 4'h9;
    cyc();
    check("t5_lock_cpu_held", o_cg, 1'b0);
    check("t5_lock_state", o_state, 2'd3);
    cyc();
    check("t5_lock_cpu_held2", o_cg, 1'b0);
    aux_lock = 0;
    cyc();
    check("t5_release_state", o_state, 2'd3);
    aux_req = 0;
    cyc();
    check("t5_exit_state", o_state, 2'd1);
    check("t5_cpu_gnt", o_cg, 1'b1);
    cpu_req = 0; cpu_we = 0;
    cyc();

    // Reset while locked with a read response in flight.
    aux_req = 1; aux_we = 0; aux_addr = 6'h15; aux_lock = 1;
    cyc();
    cyc();
    check("t6_locked", o_state, 2'd3);
    rst = 1;
    cyc();
    check("t6_rst_cpu_gnt", o_cg, 1'b0);
    check("t6_rst_aux_gnt", o_ag, 1'b0);
    check("t6_rst_we", o_we, 1'b0);
    rst = 0;
    cyc();
    check("t6_state", o_state, 2'd0);
    check("t6_rvalid", o_arv, 1'b0);
    check("t6_rdata", o_ard, 4'h0);
    aux_lock = 0; aux_req = 0;
    cyc();
    cyc();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      cyc();
    end
    rst = 0; cpu_req = 0; aux_req = 0; aux_lock = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
